regfile_rename: RTL
===================

Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo RISC-V core. Sits directly downstream of the reorder buffer.
- Consumes the ROB commit stream (rd, value, rename tag, enable) and writes architectural values. A tag is cleared only when the committing ROB entry is still the newest producer of that register.
- Upstream, the decoder reads operands (value + rename tag) and installs a new tag for each dispatched instruction's rd.
- On branch mispredict flush, all rename tags are discarded.

Parameters:
- NREG, 32, number of architectural registers.
- TAGW, 5, rename tag width; bit 4 set means "not renamed".
- NULL_TAG, 16, tag value meaning "value is architectural/ready".
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when 0, all state holds
- flush  in  1  mispredict (ROB jump_wrong); clears all tags
- commit_en  in  1  ROB commit valid (enable_reg)
- commit_rd  in  5  destination register of committing instruction
- commit_value  in  XLEN  committed result
- commit_tag  in  TAGW  ROB index of committing entry
- rename_en  in  1  decoder installs a new producer
- rename_rd  in  5  register being renamed
- rename_tag  in  TAGW  ROB free tag assigned (never NULL_TAG when rename_en=1)
- rs1_idx  in  5  decoder operand 1 index
- rs2_idx  in  5  decoder operand 2 index
- rs1_value  out  XLEN  operand 1 value
- rs1_tag  out  TAGW  operand 1 producer tag or NULL_TAG
- rs2_value  out  XLEN  operand 2 value
- rs2_tag  out  TAGW  operand 2 producer tag or NULL_TAG
- renamed_cnt  out  6  registered count of registers whose tag != NULL_TAG

Behaviour:
- State: value[0..31] (XLEN), tag[0..31] (TAGW).
- Reset (async, rst=1): all values 0, all tags NULL_TAG, renamed_cnt=0. Outputs therefore read 0 / NULL_TAG.
- All updates on posedge clk, only when rdy=1 and rst=0.
- x0:
  - Never written and never renamed; commit_rd=0 and rename_rd=0 are ignored.
  - Reads of x0 always return value 0 and NULL_TAG.
- Commit (commit_en=1, commit_rd!=0):
  - value[rd] <= commit_value, unconditionally.
  - tag[rd] <= NULL_TAG only if tag[rd]==commit_tag; otherwise a younger producer owns rd and its tag is kept.
- Rename (rename_en=1, rename_rd!=0): tag[rd] <= rename_tag.
- Commit and rename in the same cycle, same rd:
  - Rename wins the tag.
  - Value is still written.
- Flush:
  - All tags <= NULL_TAG, and any same-cycle rename is dropped.
  - A same-cycle commit still writes its value.
  - Flush takes priority over the tag updates of both commit and rename.
- Reads are combinational, from the current state plus the optional bypass.
- renamed_cnt is a registered popcount of next-state tags that differ from NULL_TAG. It is updated every enabled cycle, and it is 0 the cycle after a flush.
- rdy=0: no write, rename or flush takes effect; reads remain valid.
- Tags are 5-bit throughout; only tag[3:0] identifies the ROB entry when bit 4 is 0.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Read ports forward the same-cycle commit. If commit_en=1, rsX_idx==commit_rd!=0 and the stored tag equals commit_tag, the port returns commit_value with NULL_TAG.
  - Same-cycle rename is not forwarded to reads.
- Undefined: reads reflect registered state only, and the decoder observes the commit one cycle later.

Decomposition:
- Shared package/define file holds:
  - XLEN, REGINDEX width (5) and TAGW.
  - NULL_TAG (16) and ROB size (16).
  - TRUE/FALSE constants.
- One sub-module, regfile_read_port, instantiated twice. It handles the x0 rule and the optional commit bypass mux; its inputs are the index, the stored value/tag arrays' selected entries and the commit bus.

Test Plan:
- Reset mid-operation: rename x5->tag 3, assert rst asynchronously between edges -> rs1_idx=5 immediately reads value 0, tag 16; renamed_cnt=0.
- Rename then matching commit: rename x5 tag 3; next cycle commit rd=5, value 0xDEADBEEF, tag 3 -> after edge rs1 reads 0xDEADBEEF, tag 16.
- Stale commit: rename x7 tag 2, then rename x7 tag 9, then commit rd=7 tag 2 value 0x11 -> value 0x11, tag stays 9; renamed_cnt=1.
- Same-cycle commit+rename on x4: tag[4]=1, commit tag 1 value 0x55 with rename x4 tag 6 -> value 0x55, tag 6.
- Flush: rename x1..x10 with tags 0..9, then flush with commit rd=3 tag 2 value 0x77 and rename x12 tag 10 -> all tags 16, x3=0x77, x12 not renamed, renamed_cnt=0.
- x0 and bypass:
  - Commit rd=0 value 0xFF and rename x0 tag 4 -> rs1_idx=0 reads 0, tag 16.
  - With REGFILE_BYPASS_EN, tag[8]=5 and commit rd=8 tag 5 value 0xAB -> rs2 reads 0xAB/16 in the same cycle.
  - Without REGFILE_BYPASS_EN, the same stimulus reads the old value/5, then 0xAB/16 next cycle.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// regfile_rename_pkg
// Shared constants for the renaming architectural register file of the
// Tomasulo RISC-V core: data width, register index width, rename tag width,
// the "not renamed" tag value and the ROB depth that tags index into.
// No ports (package only).

package regfile_rename_pkg;

    localparam int XLEN     = 32;
    localparam int REGW     = 5;
    localparam int NREG     = 32;
    localparam int TAGW     = 5;
    localparam int ROB_SIZE = 16;

    // Bit 4 set marks a tag that does not name a ROB entry; 16 is the
    // canonical "value is architectural and ready" marker.
    localparam logic [TAGW-1:0] NULL_TAG = 5'd16;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    function automatic logic tag_is_pending(input logic [TAGW-1:0] t);
        return t != NULL_TAG;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One decoder operand port. Applies the x0 rule (always 0 / NULL_TAG) and,
// when REGFILE_BYPASS_EN is defined, forwards a same-cycle ROB commit whose
// tag still owns the register.
// Ports:
//   idx           operand register index
//   stored_value  value array entry selected by idx
//   stored_tag    tag array entry selected by idx
//   commit_en     commit bus valid (already qualified by rdy/rst)
//   commit_rd     commit destination register
//   commit_value  commit result
//   commit_tag    ROB index of the committing entry
//   value, tag    operand value and producer tag (NULL_TAG when ready)
// Build option: `define REGFILE_BYPASS_EN enables the commit bypass.

module regfile_read_port
    import regfile_rename_pkg::*;
(
    input  logic [REGW-1:0] idx,
    input  logic [XLEN-1:0] stored_value,
    input  logic [TAGW-1:0] stored_tag,
    input  logic            commit_en,
    input  logic [REGW-1:0] commit_rd,
    input  logic [XLEN-1:0] commit_value,
    input  logic [TAGW-1:0] commit_tag,
    output logic [XLEN-1:0] value,
    output logic [TAGW-1:0] tag
);

`ifdef REGFILE_BYPASS_EN
    // idx==commit_rd together with the x0 check first guarantees commit_rd!=0.
    always_comb begin
        value = stored_value;
        tag   = stored_tag;
        if (idx == '0) begin
            value = '0;
            tag   = NULL_TAG;
        end else if (commit_en && (commit_rd == idx) && (stored_tag == commit_tag)) begin
            value = commit_value;
            tag   = NULL_TAG;
        end
    end
`else
    logic unused_commit_bus;
    assign unused_commit_bus = ^{commit_en, commit_rd, commit_value, commit_tag};

    always_comb begin
        value = stored_value;
        tag   = stored_tag;
        if (idx == '0) begin
            value = '0;
            tag   = NULL_TAG;
        end
    end
`endif

endmodule

// File: rtl/regfile_rename.sv
// regfile_rename
// Architectural register file with per-register rename tags, fed by the ROB
// commit stream and read/renamed by the decoder. A commit clears the tag only
// while its ROB entry is still the newest producer; a flush discards all tags.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global enable; all state holds when low
//   flush             mispredict: all tags return to NULL_TAG
//   commit_*          ROB commit bus (enable, rd, value, tag)
//   rename_*          decoder rename request (enable, rd, new tag)
//   rs1_idx, rs2_idx  operand indices
//   rs1_*/rs2_*       operand value and producer tag
//   renamed_cnt       registered count of registers with a pending tag
// Build option: `define REGFILE_BYPASS_EN forwards same-cycle commits to reads.

module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            commit_en,
    input  logic [REGW-1:0] commit_rd,
    input  logic [XLEN-1:0] commit_value,
    input  logic [TAGW-1:0] commit_tag,
    input  logic            rename_en,
    input  logic [REGW-1:0] rename_rd,
    input  logic [TAGW-1:0] rename_tag,
    input  logic [REGW-1:0] rs1_idx,
    input  logic [REGW-1:0] rs2_idx,
    output logic [XLEN-1:0] rs1_value,
    output logic [TAGW-1:0] rs1_tag,
    output logic [XLEN-1:0] rs2_value,
    output logic [TAGW-1:0] rs2_tag,
    output logic [5:0]      renamed_cnt
);

    logic [XLEN-1:0] reg_value [NREG];
    logic [TAGW-1:0] reg_tag   [NREG];
    logic [TAGW-1:0] tag_next  [NREG];
    logic [5:0]      cnt_next;
    logic            commit_live;
    logic            rename_live;

    assign commit_live = commit_en && (commit_rd != '0);
    assign rename_live = rename_en && (rename_rd != '0);

    // Tag update priority: matching commit clears, rename overrides it,
    // flush overrides everything.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            tag_next[i] = reg_tag[i];
        end
        if (commit_live && (reg_tag[commit_rd] == commit_tag)) begin
            tag_next[commit_rd] = NULL_TAG;
        end
        if (rename_live) begin
            tag_next[rename_rd] = rename_tag;
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                tag_next[i] = NULL_TAG;
            end
        end
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            if (tag_is_pending(tag_next[i])) begin
                cnt_next = cnt_next + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_value[i] <= '0;
                reg_tag[i]   <= NULL_TAG;
            end
            renamed_cnt <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NREG; i++) begin
                reg_tag[i] <= tag_next[i];
            end
            // The value is written even when flush or a rename takes the tag.
            if (commit_live) begin
                reg_value[commit_rd] <= commit_value;
            end
            renamed_cnt <= cnt_next;
        end
    end

    // A commit that will not take effect this cycle must not be forwarded.
    logic bypass_en;
    assign bypass_en = commit_en && rdy && !rst;

    regfile_read_port u_rs1 (
        .idx          (rs1_idx),
        .stored_value (reg_value[rs1_idx]),
        .stored_tag   (reg_tag[rs1_idx]),
        .commit_en    (bypass_en),
        .commit_rd    (commit_rd),
        .commit_value (commit_value),
        .commit_tag   (commit_tag),
        .value        (rs1_value),
        .tag          (rs1_tag)
    );

    regfile_read_port u_rs2 (
        .idx          (rs2_idx),
        .stored_value (reg_value[rs2_idx]),
        .stored_tag   (reg_tag[rs2_idx]),
        .commit_en    (bypass_en),
        .commit_rd    (commit_rd),
        .commit_value (commit_value),
        .commit_tag   (commit_tag),
        .value        (rs2_value),
        .tag          (rs2_tag)
    );

endmodule
